// File: rtl/deque_pkg.sv
// Shared types and index helpers for the bounded deque.
// Holds the operation encoding and modular index arithmetic.
// The helpers use compare-and-subtract, so DEPTH need not be a power of two.
package deque_pkg;

  typedef enum logic [1:0] {
    PUSH_BACK  = 2'd0,
    PUSH_FRONT = 2'd1,
    POP_FRONT  = 2'd2,
    POP_BACK   = 2'd3
  } deque_op_e;

  // idx + 1, wrapping DEPTH-1 -> 0. idx must be < depth.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    if (idx + 32'd1 >= depth) return 32'd0;
    return idx + 32'd1;
  endfunction

  // idx - 1, wrapping 0 -> DEPTH-1. idx must be < depth.
  function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned depth);
    if (idx == 32'd0) return depth - 32'd1;
    return idx - 32'd1;
  endfunction

  // (idx + off) wrapped, for idx < depth and off <= depth.
  // One subtraction is enough because the sum stays below 2*depth.
  function automatic int unsigned wrap_add(input int unsigned idx, input int unsigned off,
                                           input int unsigned depth);
    int unsigned s;
    s = idx + off;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/deque_storage.sv
// Element storage for the bounded deque: one write port, three async read ports.
// Latency: writes land on the next rising edge; reads are combinational.
// Backpressure: none; the controller guarantees indices are always in range.
//
// Ports:
//   clk                     clock
//   wr_en/wr_idx/wr_data    single write port
//   front_idx -> front_rd   read port for the head element
//   back_idx  -> back_rd    read port for the tail element
//   pop_idx   -> pop_rd     read port feeding the popped-data register
module deque_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    front_idx,
  input  logic [AW-1:0]    back_idx,
  input  logic [AW-1:0]    pop_idx,
  output logic [WIDTH-1:0] front_rd,
  output logic [WIDTH-1:0] back_rd,
  output logic [WIDTH-1:0] pop_rd
);

  // Contents are intentionally not reset: occupancy lives in the controller,
  // and unoccupied slots are never observed.
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign front_rd = mem_q[front_idx];
  assign back_rd  = mem_q[back_idx];
  assign pop_rd   = mem_q[pop_idx];

endmodule

// File: rtl/bounded_deque.sv
// Bounded double-ended queue with SV [$:DEPTH-1] overflow/underflow semantics.
// Latency: one op per cycle; popped data and flag pulses appear the next cycle.
// Backpressure: none; every op is accepted, excess pushes are discarded.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous clear, wins over op_valid
//   op_valid, op, op_data    operation request (deque_op_e) and push payload
//   rd_valid, rd_data        registered pop response ('0 on underflow)
//   overflow, underflow      registered one-cycle event pulses
//   count, empty, full       occupancy
//   front_data, back_data    combinational head/tail peek, '0 when empty
module bounded_deque
  import deque_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       op_valid,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           op_data,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [WIDTH-1:0]           front_data,
  output logic [WIDTH-1:0]           back_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    head_q, head_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [AW-1:0]    head_inc, head_dec, push_back_idx, tail_idx, pop_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] front_rd, back_rd, pop_rd;
  logic             is_empty, is_full;
  deque_op_e        op_e;

  assign op_e     = deque_op_e'(op);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Index arithmetic. push_back_idx is the first free slot after the tail;
  // tail_idx is one before it, which is only meaningful when count > 0.
  assign head_inc      = AW'(wrap_inc(32'(head_q), DEPTH));
  assign head_dec      = AW'(wrap_dec(32'(head_q), DEPTH));
  assign push_back_idx = AW'(wrap_add(32'(head_q), 32'(count_q), DEPTH));
  assign tail_idx      = AW'(wrap_dec(32'(push_back_idx), DEPTH));
  assign pop_idx       = (op_e == POP_BACK) ? tail_idx : head_q;

  deque_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (op_data),
    .front_idx (head_q),
    .back_idx  (tail_idx),
    .pop_idx   (pop_idx),
    .front_rd  (front_rd),
    .back_rd   (back_rd),
    .pop_rd    (pop_rd)
  );

  always_comb begin
    head_d      = head_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = push_back_idx;

    if (flush) begin
      // Head is re-centred only here and on reset, never when count drains.
      head_d  = '0;
      count_d = '0;
    end else if (op_valid) begin
      unique case (op_e)
        PUSH_BACK: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = push_back_idx;
            count_d = count_q + CW'(1);
          end
        end
        PUSH_FRONT: begin
          // When full, the slot before head is the current tail, so the
          // write itself evicts the back element.
          wr_en  = 1'b1;
          wr_idx = head_dec;
          head_d = head_dec;
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        POP_FRONT, POP_BACK: begin
          rd_valid_d = 1'b1;
          if (is_empty) begin
            rd_data_d   = '0;
            underflow_d = 1'b1;
          end else begin
            rd_data_d = pop_rd;
            count_d   = count_q - CW'(1);
            if (op_e == POP_FRONT) begin
              head_d = head_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign front_data = is_empty ? '0 : front_rd;
  assign back_data  = is_empty ? '0 : back_rd;

endmodule

// File: tb/tb_bounded_deque.sv
// Self-checking bench for bounded_deque (WIDTH=8, DEPTH=5).
// A queue model tracks contents; expected pop results go to a scoreboard.
// Outputs are sampled 1ns after each rising edge.
module tb_bounded_deque;
  import deque_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             op_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_data;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] front_data;
  logic [WIDTH-1:0] back_data;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq[$];  // reference contents, index 0 = front
  logic [WIDTH-1:0] sb[$];  // expected rd_data, in pop order

  always #5 clk = ~clk;

  bounded_deque #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .op_valid   (op_valid),
    .op         (op),
    .op_data    (op_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .overflow   (overflow),
    .underflow  (underflow),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .front_data (front_data),
    .back_data  (back_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, update the model, sample after posedge.
  task automatic step(input logic r, input logic f, input logic v,
                      input deque_op_e o, input logic [WIDTH-1:0] d);
    logic e_rdv, e_ovf, e_udf;
    e_rdv = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    @(negedge clk);
    rst = r; flush = f; op_valid = v; op = o; op_data = d;
    if (r || f) begin
      mq.delete();
      if (r) sb.delete();
    end else if (v) begin
      case (o)
        PUSH_BACK: begin
          if (mq.size() < DEPTH) mq.push_back(d);
          else e_ovf = 1'b1;
        end
        PUSH_FRONT: begin
          if (mq.size() == DEPTH) begin
            void'(mq.pop_back());
            e_ovf = 1'b1;
          end
          mq.push_front(d);
        end
        POP_FRONT, POP_BACK: begin
          e_rdv = 1'b1;
          if (mq.size() == 0) begin
            sb.push_back('0);
            e_udf = 1'b1;
          end else if (o == POP_FRONT) begin
            sb.push_back(mq.pop_front());
          end else begin
            sb.push_back(mq.pop_back());
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0;
    check("rd_valid", rd_valid, e_rdv);
    check("overflow", overflow, e_ovf);
    check("underflow", underflow, e_udf);
    if (rd_valid) begin
      if (sb.size() == 0) check("rd_spurious", rd_valid, 0);
      else check("rd_data", rd_data, sb.pop_front());
    end
    if (r) check("rst_rd_data", rd_data, 0);
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("front", front_data, (mq.size() > 0) ? mq[0] : '0);
    check("back", back_data, (mq.size() > 0) ? mq[mq.size()-1] : '0);
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d); step(0, 0, 1, PUSH_BACK, d); endtask
  task automatic push_f(input logic [WIDTH-1:0] d); step(0, 0, 1, PUSH_FRONT, d); endtask
  task automatic pop_f(); step(0, 0, 1, POP_FRONT, '0); endtask
  task automatic pop_b(); step(0, 0, 1, POP_BACK, '0); endtask

  initial begin
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 2'd0; op_data = '0;
    step(1, 0, 0, PUSH_BACK, '0);
    step(1, 0, 0, PUSH_BACK, '0);
    step(0, 0, 0, PUSH_BACK, '0);  // idle cycle after reset

    // 1: basic FIFO order
    push_b(8'h11); push_b(8'h22); push_b(8'h33);
    pop_f(); pop_f(); pop_f();
    check("t1_empty", empty, 1);

    // 2: fill, overflow on push_back, pop_back
    for (int i = 1; i <= 5; i++) push_b(8'(i));
    check("t2_full", full, 1);
    push_b(8'h06);
    check("t2_ovf", overflow, 1);
    pop_b();
    check("t2_popb", rd_data, 8'h05);

    // 3: push_front on full evicts the back element
    push_b(8'h05);
    push_f(8'hAA);
    check("t3_front", front_data, 8'hAA);
    check("t3_back", back_data, 8'h04);
    check("t3_count", count, 5);
    for (int i = 0; i < 5; i++) pop_f();

    // 4: underflow at both ends
    pop_f();
    check("t4_udf_f", underflow, 1);
    pop_b();
    check("t4_udf_b", underflow, 1);

    // 5: wrap-around from a known head position
    step(1, 0, 0, PUSH_BACK, '0);
    for (int i = 0; i < 4; i++) push_b(8'(8'h10 + i));
    for (int i = 0; i < 3; i++) pop_f();
    for (int i = 0; i < 4; i++) push_b(8'(8'h14 + i));
    check("t5_full", full, 1);
    for (int i = 0; i < 5; i++) pop_f();
    check("t5_last", rd_data, 8'h17);

    // 6a: flush beats a concurrent push
    push_b(8'h41); push_b(8'h42); push_b(8'h43);
    step(0, 1, 1, PUSH_BACK, 8'h99);
    check("t6_flush_count", count, 0);
    pop_f();  // must underflow: 0x99 was not stored

    // 6b: reset mid-sequence with an op present
    push_b(8'h51); push_f(8'h52); pop_b();
    push_b(8'h53); push_b(8'h54);
    step(1, 0, 1, PUSH_BACK, 8'h77);
    check("t6_rst_count", count, 0);
    check("t6_rst_front", front_data, 0);
    push_f(8'h61); push_f(8'h62); pop_b(); pop_b();

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bounded_deque.md
Name: bounded_deque

Overview:
- Synthesizable bounded double-ended queue. It is the hardware counterpart of a SystemVerilog bounded queue `[$:N]`.
- Sits downstream of the type-checked declarations in the svlog lowering tests. It is the RTL the lowering stage must produce and simulate for queue-typed storage.
- Accepts one operation per cycle (push/pop at either end) and returns popped data one cycle later.
- Overflow and underflow follow SV bounded-queue semantics: excess elements are discarded, and a pop on an empty queue returns the default value.

Parameters:
- WIDTH, 8, element width in bits.
- DEPTH, 5, capacity in elements (equivalent to `[$:DEPTH-1]`). Any value >= 2; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear; priority over op_valid.
- op_valid  input  1  operation request this cycle.
- op  input  2  operation code: deque_op_e.
- op_data  input  WIDTH  push payload; ignored for pops.
- rd_valid  output  1  registered; pulses 1 cycle after any accepted pop.
- rd_data  output  WIDTH  registered popped element.
- overflow  output  1  registered 1-cycle pulse when a push discards an element.
- underflow  output  1  registered 1-cycle pulse when a pop finds the queue empty.
- count  output  $clog2(DEPTH+1)  current occupancy, registered.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- front_data  output  WIDTH  combinational mem[head]; '0 when empty.
- back_data  output  WIDTH  combinational mem[tail]; '0 when empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: head=0, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0. Storage array is not reset.
- Storage: packed array `logic [DEPTH-1:0][WIDTH-1:0]` with circular head index.
  - tail = head+count-1, wrapped.
  - All wraps use explicit compare-and-subtract; no % operator.
- Every op_valid cycle is accepted; there is no back-pressure. rd_valid, overflow and underflow deassert on any cycle with no qualifying event.
- PUSH_BACK (0):
  - count<DEPTH: write mem[head+count wrapped]; count+1.
  - full: element dropped, state unchanged, overflow=1 next cycle.
- PUSH_FRONT (1):
  - Always: head = head-1 (0 wraps to DEPTH-1); write mem[new head].
  - count<DEPTH: count+1.
  - full: count unchanged, old back element is discarded (overwritten), overflow=1 next cycle.
- POP_FRONT (2):
  - count>0: rd_data<=mem[head]; head+1 wrapped; count-1; rd_valid=1.
  - empty: rd_valid=1, rd_data='0, underflow=1, state unchanged.
- POP_BACK (3):
  - count>0: rd_data<=mem[tail]; count-1; head unchanged; rd_valid=1.
  - empty: same response as POP_FRONT on empty.
- Latency: pop data is visible on the cycle after the op. front_data, back_data, empty and full reflect the post-update state on that same cycle.
- flush: head=0, count=0. Any concurrent op is ignored; no rd_valid, overflow or underflow. Takes effect next cycle.
- rst has priority over flush and op. Reset asserted mid-sequence discards all contents, and outputs take reset values the next cycle.
- When count returns to 0, head is not re-centred.

Decomposition:
- Package deque_pkg holds:
  - typedef enum logic [1:0] deque_op_e {PUSH_BACK, PUSH_FRONT, POP_FRONT, POP_BACK};
  - function wrap_inc(idx, DEPTH) and function wrap_dec(idx, DEPTH).
- Sub-module deque_storage: register array with one write port and three read ports (front, back, pop), parameterised WIDTH/DEPTH.
- bounded_deque holds pointer/count control and output registers only.

Test Plan (WIDTH=8, DEPTH=5):
1. Reset, then PUSH_BACK 0x11, 0x22, 0x33, then POP_FRONT x3 -> rd_data 0x11, 0x22, 0x33, each with rd_valid one cycle after its pop; final count=0, empty=1.
2. PUSH_BACK 0x01..0x05 -> full=1. PUSH_BACK 0x06 -> overflow pulse, count=5. POP_BACK -> rd_data=0x05.
3. Full with 0x01..0x05, then PUSH_FRONT 0xAA -> overflow pulse, front_data=0xAA, back_data=0x04, count=5. POP_FRONT x5 yields 0xAA, 0x01, 0x02, 0x03, 0x04.
4. POP_FRONT, then POP_BACK, on empty -> rd_valid=1, rd_data=0x00, underflow=1 each; count stays 0.
5. Wrap-around: PUSH_BACK 0x10..0x13, POP_FRONT x3, PUSH_BACK 0x14..0x17 (head/tail cross index 4->0) -> POP_FRONT x5 yields 0x13..0x17 in order.
6. flush asserted with op_valid PUSH_BACK 0x99 while count=3 -> count=0 next cycle, 0x99 not stored, no flag pulses. Separately, rst mid-sequence -> all outputs 0 next cycle.
